// File: rtl/seat_query_if.sv
// Bundles the handshake and bus signals of the seat query reader.
//   query    : q_valid/q_ready handshake with q_mode, q_seat, cur_time, limit_time
//   memory   : mem_rd_en/mem_rd_addr strobe, mem_rd_valid with record fields
//   response : r_valid/r_ready handshake with r_found, r_seat, r_student,
//              r_state, r_remain, r_expired
// The slave modport is the reader's view; master is the view of whatever
// drives the queries, serves the memory and consumes the responses.
interface seat_query_if #(
   parameter int SEAT_W = 5,
   parameter int STU_W  = 32,
   parameter int TIME_W = 11
);
   logic              q_valid;
   logic              q_ready;
   logic              q_mode;
   logic [SEAT_W-1:0] q_seat;
   logic [TIME_W-1:0] cur_time;
   logic [TIME_W-1:0] limit_time;

   logic              mem_rd_en;
   logic [SEAT_W-1:0] mem_rd_addr;
   logic              mem_rd_valid;
   logic [STU_W-1:0]  mem_rd_student;
   logic [TIME_W-1:0] mem_rd_time;
   logic [1:0]        mem_rd_state;
   logic [1:0]        mem_rd_ban;

   logic              r_valid;
   logic              r_ready;
   logic              r_found;
   logic [SEAT_W-1:0] r_seat;
   logic [STU_W-1:0]  r_student;
   logic [1:0]        r_state;
   logic [TIME_W-1:0] r_remain;
   logic              r_expired;

   modport slave (
      input  q_valid, q_mode, q_seat, cur_time, limit_time,
      input  mem_rd_valid, mem_rd_student, mem_rd_time, mem_rd_state, mem_rd_ban,
      input  r_ready,
      output q_ready, mem_rd_en, mem_rd_addr,
      output r_valid, r_found, r_seat, r_student, r_state, r_remain, r_expired
   );

   modport master (
      output q_valid, q_mode, q_seat, cur_time, limit_time,
      output mem_rd_valid, mem_rd_student, mem_rd_time, mem_rd_state, mem_rd_ban,
      output r_ready,
      input  q_ready, mem_rd_en, mem_rd_addr,
      input  r_valid, r_found, r_seat, r_student, r_state, r_remain, r_expired
   );
endinterface

// File: rtl/seat_query_reader.sv
// Read-side query engine for the seat record memory. Accepts a lookup of one
// seat or a scan for the first free, unbanned seat, reads records over the
// strobe/valid memory port and returns status, occupant, remaining minutes
// and expiry over the response handshake.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset; aborts any query in flight
//   bus   - seat_query_if.slave: query, memory read and response signals
//
// state  | meaning
// IDLE   | q_ready high, waiting for a query
// ISSUE  | mem_rd_en pulse for addr_q
// WAIT   | waiting for mem_rd_valid, record captured on arrival
// EVAL   | compute result; scan may step to the next seat
// RESP   | r_valid high, result held until r_ready
module seat_query_reader #(
   parameter int NUM_SEATS = 32,
   parameter int SEAT_W    = 5,
   parameter int STU_W     = 32,
   parameter int TIME_W    = 11,
   parameter int TIME_WRAP = 1080
) (
   input  logic        clk,
   input  logic        rst_n,
   seat_query_if.slave bus
);
   localparam logic [SEAT_W:0]   NUM_SEATS_X = (SEAT_W+1)'(NUM_SEATS);
   localparam logic [SEAT_W:0]   LAST_CNT    = (SEAT_W+1)'(NUM_SEATS - 1);
   localparam logic [SEAT_W-1:0] LAST_SEAT   = SEAT_W'(NUM_SEATS - 1);
   localparam logic [TIME_W:0]   WRAP_X      = (TIME_W+1)'(TIME_WRAP);
   localparam logic [1:0]        ST_FREE     = 2'd0;
   localparam logic [1:0]        ST_OCC      = 2'd1;
   localparam logic [1:0]        ST_AWAY     = 2'd2;

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_EVAL, S_RESP} state_t;

   state_t            state_q, state_d;
   logic              mode_q, mode_d;
   logic [SEAT_W-1:0] seat_q, seat_d;
   logic [SEAT_W-1:0] addr_q, addr_d;
   logic [SEAT_W:0]   cnt_q, cnt_d;
   logic [TIME_W-1:0] cur_q, cur_d;
   logic [TIME_W-1:0] limit_q, limit_d;
   logic [STU_W-1:0]  rec_student_q, rec_student_d;
   logic [TIME_W-1:0] rec_time_q, rec_time_d;
   logic [1:0]        rec_state_q, rec_state_d;
   logic [1:0]        rec_ban_q, rec_ban_d;
   logic              r_found_q, r_found_d;
   logic [SEAT_W-1:0] r_seat_q, r_seat_d;
   logic [STU_W-1:0]  r_student_q, r_student_d;
   logic [1:0]        r_state_q, r_state_d;
   logic [TIME_W-1:0] r_remain_q, r_remain_d;
   logic              r_expired_q, r_expired_d;

   logic [TIME_W:0]   elapsed;
   logic              over;
   logic [TIME_W-1:0] remain;
   logic              timed;
   logic              rec_hit;
   logic              q_seat_oor;

   // Elapsed time handles one timer wrap since check-in; the extra bit keeps
   // cur+TIME_WRAP from overflowing before the subtraction.
   always_comb begin
      elapsed = '0;
      if (cur_q >= rec_time_q) begin
         elapsed = {1'b0, cur_q} - {1'b0, rec_time_q};
      end else begin
         elapsed = {1'b0, cur_q} + WRAP_X - {1'b0, rec_time_q};
      end
      over    = (elapsed >= {1'b0, limit_q});
      // elapsed < limit here, so the low bits hold the full difference
      remain  = over ? '0 : (limit_q - elapsed[TIME_W-1:0]);
      timed   = (rec_state_q == ST_OCC) || (rec_state_q == ST_AWAY);
      rec_hit = (rec_state_q == ST_FREE) && (rec_ban_q == 2'd0);
   end

   assign q_seat_oor = ({1'b0, bus.q_seat} >= NUM_SEATS_X);

   always_comb begin
      state_d       = state_q;
      mode_d        = mode_q;
      seat_d        = seat_q;
      addr_d        = addr_q;
      cnt_d         = cnt_q;
      cur_d         = cur_q;
      limit_d       = limit_q;
      rec_student_d = rec_student_q;
      rec_time_d    = rec_time_q;
      rec_state_d   = rec_state_q;
      rec_ban_d     = rec_ban_q;
      r_found_d     = r_found_q;
      r_seat_d      = r_seat_q;
      r_student_d   = r_student_q;
      r_state_d     = r_state_q;
      r_remain_d    = r_remain_q;
      r_expired_d   = r_expired_q;

      unique case (state_q)
         S_IDLE: begin
            // q_ready is high throughout IDLE, so q_valid alone is the handshake
            if (bus.q_valid) begin
               mode_d  = bus.q_mode;
               seat_d  = bus.q_seat;
               cur_d   = bus.cur_time;
               limit_d = bus.limit_time;
               cnt_d   = '0;
               if (!bus.q_mode && q_seat_oor) begin
                  r_found_d   = 1'b0;
                  r_seat_d    = bus.q_seat;
                  r_student_d = '0;
                  r_state_d   = '0;
                  r_remain_d  = '0;
                  r_expired_d = 1'b0;
                  state_d     = S_RESP;
               end else begin
                  addr_d  = q_seat_oor ? '0 : bus.q_seat;
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            if (bus.mem_rd_valid) begin
               rec_student_d = bus.mem_rd_student;
               rec_time_d    = bus.mem_rd_time;
               rec_state_d   = bus.mem_rd_state;
               rec_ban_d     = bus.mem_rd_ban;
               state_d       = S_EVAL;
            end
         end
         S_EVAL: begin
            state_d = S_RESP;
            if (!mode_q || rec_hit) begin
               r_found_d   = 1'b1;
               r_seat_d    = addr_q;
               r_student_d = rec_student_q;
               r_state_d   = rec_state_q;
               r_remain_d  = timed ? remain : '0;
               r_expired_d = timed && over;
            end else if (cnt_q == LAST_CNT) begin
               r_found_d   = 1'b0;
               r_seat_d    = seat_q;
               r_student_d = '0;
               r_state_d   = '0;
               r_remain_d  = '0;
               r_expired_d = 1'b0;
            end else begin
               addr_d  = (addr_q == LAST_SEAT) ? '0 : addr_q + 1'b1;
               cnt_d   = cnt_q + 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_RESP: begin
            if (bus.r_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         mode_q        <= 1'b0;
         seat_q        <= '0;
         addr_q        <= '0;
         cnt_q         <= '0;
         cur_q         <= '0;
         limit_q       <= '0;
         rec_student_q <= '0;
         rec_time_q    <= '0;
         rec_state_q   <= '0;
         rec_ban_q     <= '0;
         r_found_q     <= 1'b0;
         r_seat_q      <= '0;
         r_student_q   <= '0;
         r_state_q     <= '0;
         r_remain_q    <= '0;
         r_expired_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         mode_q        <= mode_d;
         seat_q        <= seat_d;
         addr_q        <= addr_d;
         cnt_q         <= cnt_d;
         cur_q         <= cur_d;
         limit_q       <= limit_d;
         rec_student_q <= rec_student_d;
         rec_time_q    <= rec_time_d;
         rec_state_q   <= rec_state_d;
         rec_ban_q     <= rec_ban_d;
         r_found_q     <= r_found_d;
         r_seat_q      <= r_seat_d;
         r_student_q   <= r_student_d;
         r_state_q     <= r_state_d;
         r_remain_q    <= r_remain_d;
         r_expired_q   <= r_expired_d;
      end
   end

   assign bus.q_ready     = (state_q == S_IDLE);
   assign bus.mem_rd_en   = (state_q == S_ISSUE);
   assign bus.mem_rd_addr = addr_q;
   assign bus.r_valid     = (state_q == S_RESP);
   assign bus.r_found     = r_found_q;
   assign bus.r_seat      = r_seat_q;
   assign bus.r_student   = r_student_q;
   assign bus.r_state     = r_state_q;
   assign bus.r_remain    = r_remain_q;
   assign bus.r_expired   = r_expired_q;
endmodule
